// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  localparam int          DIV_ITER  = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
endpackage

// File: rtl/ADD_SUB32.sv
// Combinational 32-bit adder/subtractor; SUB=1 computes A-B with borrow out.
module ADD_SUB32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        SUB,
  output logic [31:0] ANS,
  output logic        CY_BR_OUT
);
  always_comb begin
    if (SUB) {CY_BR_OUT, ANS} = {1'b0, A} - {1'b0, B};
    else     {CY_BR_OUT, ANS} = {1'b0, A} + {1'b0, B};
  end
endmodule

// File: rtl/div32_seq.sv
// Restoring 32-bit divider, one quotient bit per cycle, signed or unsigned.
module div32_seq
  import div_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        SIGNED_OP,
  input  logic [31:0] DIVIDEND,
  input  logic [31:0] DIVISOR,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] QUOT,
  output logic [31:0] REM,
  output logic        DIV_ZERO
);
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] r_q, r_d, q_q, q_d, d_q, d_d, dvd_q, dvd_d;
  logic [31:0] quot_q, quot_d, rem_q, rem_d;
  logic        neg_q_q, neg_q_d, neg_r_q, neg_r_d, zero_q, zero_d;
  logic        busy_q, done_q, dz_q, dz_d;

  logic [31:0] shin, add_a, add_b, ans;
  logic        taken, unused_cy;

  // In FIX the adder is reused as 0 - Q to negate the quotient.
  assign shin  = {r_q[30:0], q_q[31]};
  assign add_a = (state_q == FIX) ? 32'd0 : shin;
  assign add_b = (state_q == FIX) ? q_q : d_q;

  ADD_SUB32 u_add_sub (
    .A(add_a), .B(add_b), .SUB(1'b1), .ANS(ans), .CY_BR_OUT(unused_cy)
  );

  // 33-bit compare {R[31],S} >= D folded into the sign bits of the 32-bit difference.
  assign taken = r_q[31] | (shin[31] & ~d_q[31]) | ((shin[31] == d_q[31]) & ~ans[31]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (START) state_d = (DIVISOR == 32'd0) ? FIX : CALC;
      CALC: if (cnt_q == 5'(DIV_ITER - 1)) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    dvd_d   = dvd_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (START) begin
        dvd_d   = DIVIDEND;
        q_d     = (SIGNED_OP & DIVIDEND[31]) ? -DIVIDEND : DIVIDEND;
        d_d     = (SIGNED_OP & DIVISOR[31])  ? -DIVISOR  : DIVISOR;
        neg_q_d = SIGNED_OP & (DIVIDEND[31] ^ DIVISOR[31]);
        neg_r_d = SIGNED_OP & DIVIDEND[31];
        zero_d  = (DIVISOR == 32'd0);
        r_d     = 32'd0;
        cnt_d   = 5'd0;
      end
      CALC: begin
        r_d   = taken ? ans : shin;
        q_d   = {q_q[30:0], taken};
        cnt_d = cnt_q + 5'd1;
      end
      FIX: begin
        if (zero_q) begin
          quot_d = DIV0_QUOT;
          rem_d  = dvd_q;
          dz_d   = 1'b1;
        end else begin
          quot_d = neg_q_q ? ans : q_q;
          rem_d  = neg_r_q ? -r_q : r_q;
          dz_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      dvd_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      dvd_q   <= dvd_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == FIX);
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign QUOT     = quot_q;
  assign REM      = rem_q;
  assign DIV_ZERO = dz_q;
endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq with hand-computed quotient/remainder vectors.
module tb_div32_seq;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0, SIGNED_OP = 1'b0;
  logic [31:0] DIVIDEND = '0, DIVISOR = '0;
  logic        BUSY, DONE, DIV_ZERO;
  logic [31:0] QUOT, REM;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, t0 = 0, lat = 0, bsy = 0, dones = 0;

  div32_seq dut (
    .CLK(CLK), .RST(RST), .START(START), .SIGNED_OP(SIGNED_OP),
    .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR), .BUSY(BUSY), .DONE(DONE),
    .QUOT(QUOT), .REM(REM), .DIV_ZERO(DIV_ZERO)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge; START is sampled at the next edge (e0).
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    START = 1'b1; SIGNED_OP = sgn; DIVIDEND = a; DIVISOR = b;
    @(posedge CLK); #1;
    START = 1'b0; DIVIDEND = 32'hDEAD_BEEF; DIVISOR = 32'h0BAD_F00D;
    t0 = cyc;
    bsy = BUSY ? 1 : 0;
  endtask

  // Returns in the DONE cycle (#1 after its edge), or after a 100-cycle bound.
  task automatic wait_done(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      if (DONE) break;
      if (BUSY) bsy++;
    end
    lat = cyc - t0;
    chk({tag, "_done"}, {31'd0, DONE}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic result(input string tag, input logic [31:0] q, input logic [31:0] r,
                        input logic z, input int exp_lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_quot"}, QUOT, q);
    chk({tag, "_rem"}, REM, r);
    chk({tag, "_dz"}, {31'd0, DIV_ZERO}, {31'd0, z});
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_quot", QUOT, 32'd0);
    chk("rst_rem", REM, 32'd0);
    chk("rst_dz", {31'd0, DIV_ZERO}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    launch(1'b0, 32'd100, 32'd7);
    chk("u100_7_busy_e0", {31'd0, BUSY}, 32'd1);
    wait_done("u100_7");
    result("u100_7", 32'd14, 32'd2, 1'b0, 33);
    chk("u100_7_busy_cycles", bsy, 32'd33);
    @(posedge CLK); #1;
    chk("done_pulse_width", {31'd0, DONE}, 32'd0);
    chk("quot_holds", QUOT, 32'd14);

    launch(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done("s_m100_7");
    result("s_m100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);

    launch(1'b0, 32'hFFFF_FFFF, 32'h8000_0001);
    wait_done("u_big");
    result("u_big", 32'd1, 32'h7FFF_FFFE, 1'b0, 33);

    launch(1'b0, 32'd1234, 32'd0);
    wait_done("u_div0");
    result("u_div0", 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);

    launch(1'b1, 32'd1234, 32'd0);
    wait_done("s_div0");
    result("s_div0", 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);

    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("s_ovf");
    result("s_ovf", 32'h8000_0000, 32'd0, 1'b0, 33);

    // A START at cycle 10 of a busy operation must be dropped.
    launch(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge CLK);
    #1;
    START = 1'b1; SIGNED_OP = 1'b1; DIVIDEND = 32'd9; DIVISOR = 32'd0;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done("ignored");
    result("ignored", 32'd14, 32'd2, 1'b0, 33);

    // Back-to-back: START in the DONE cycle is accepted.
    launch(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    chk("b2b_busy_e0", {31'd0, BUSY}, 32'd1);
    wait_done("b2b");
    result("b2b", 32'd14, 32'hFFFF_FFFE, 1'b0, 33);

    // Asynchronous reset at iteration 15 aborts without DONE.
    launch(1'b0, 32'd77, 32'd3);
    repeat (15) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_quot", QUOT, 32'd0);
    chk("abort_rem", REM, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (DONE) dones++;
    end
    chk("abort_no_done", dones, 32'd0);
    chk("abort_idle", {31'd0, BUSY}, 32'd0);

    launch(1'b0, 32'd50, 32'd5);
    wait_done("u50_5");
    result("u50_5", 32'd10, 32'd0, 1'b0, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
